// File: rtl/serial_tx_sched_if.sv
// Request bus shared by the serial transmit scheduler and its requesters.
// Word i sits at req_data[i*WIDTH +: WIDTH]; a transfer happens on valid & ready.
interface serial_tx_sched_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 5
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/serial_tx_sched.sv
// Round-robin scheduler that serialises one requester word at a time onto a framed,
// LSB-first serial pin, gated by a qualified PLL lock.
module serial_tx_sched #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned LOCK_WAIT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pll_lock_i,
    serial_tx_sched_if.slave        req,
    output logic                    data_out_o,
    output logic                    busy_o,
    output logic [$clog2(NREQ)-1:0] grant_id_o
);

    localparam int unsigned IdW   = $clog2(NREQ);
    localparam int unsigned BitW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned LockW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    typedef enum logic [2:0] {
        StWaitLock,
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [IdW-1:0]    last_grant_q, last_grant_d;
    logic [IdW-1:0]    grant_id_q, grant_id_d;
    logic              data_out_q, data_out_d;
    logic              busy_q, busy_d;

    logic [IdW-1:0]    winner;
    logic              found;
    logic              handshake;
    logic [NREQ-1:0]   ready;

    // Search starts one past the last grant and wraps, so the last winner goes last.
    always_comb begin : p_arb
        int unsigned    idx;
        logic [IdW-1:0] idx_s;
        idx    = 0;
        idx_s  = '0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx   = (32'(last_grant_q) + k) % NREQ;
            idx_s = IdW'(idx);
            if (!found && req.req_valid[idx_s]) begin
                found  = 1'b1;
                winner = idx_s;
            end
        end
    end

    assign handshake = (state_q == StIdle) && pll_lock_i && found;

    always_comb begin
        ready = '0;
        if (handshake) begin
            ready[winner] = 1'b1;
        end
    end

    assign req.req_ready = ready;

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = '0;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;

        unique case (state_q)
            StWaitLock: begin
                if (pll_lock_i) begin
                    if (lock_cnt_q == LockW'(LOCK_WAIT - 1)) begin
                        state_d = StIdle;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
            end
            StIdle: begin
                if (handshake) begin
                    shift_d      = req.req_data[32'(winner) * WIDTH +: WIDTH];
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    state_d      = StStart;
                end
            end
            StStart: begin
                bit_cnt_d = '0;
                state_d   = StData;
            end
            StData: begin
                shift_d = shift_q >> 1;
                if (bit_cnt_q == BitW'(WIDTH - 1)) begin
                    state_d = StStop;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StStop: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StWaitLock;
            end
        endcase

        // Lock loss overrides everything; grant history is kept for fairness.
        if (!pll_lock_i) begin
            state_d    = StWaitLock;
            lock_cnt_d = '0;
        end
    end

    // Line level is decided from next state so the pin is registered with no input path.
    always_comb begin
        busy_d = (state_d == StStart) || (state_d == StData) || (state_d == StStop);
        unique case (state_d)
            StStart: data_out_d = 1'b0;
            StData:  data_out_d = shift_d[0];
            default: data_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StWaitLock;
            lock_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            last_grant_q <= IdW'(NREQ - 1);
            grant_id_q   <= '0;
            data_out_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            data_out_q   <= data_out_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out_o = data_out_q;
    assign busy_o     = busy_q;
    assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_serial_tx_sched.sv
// Directed bench for serial_tx_sched: lock qualification, framing, round-robin,
// abort on lock loss and synchronous reset in mid-frame.
module tb_serial_tx_sched;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned WIDTH     = 5;
    localparam int unsigned LOCK_WAIT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       data_out;
    logic       busy;
    logic [1:0] grant_id;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] dw [NREQ];

    serial_tx_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) req_if ();

    serial_tx_sched #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .LOCK_WAIT (LOCK_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_lock_i (pll_lock),
        .req        (req_if.slave),
        .data_out_o (data_out),
        .busy_o     (busy),
        .grant_id_o (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_line"}, 32'(data_out), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_ready"}, 32'(req_if.req_ready), 32'd0);
    endtask

    // Called in lock-wait cycle 0 (counter 0, lock high, inputs settled).
    task automatic lock_wait(input logic [NREQ-1:0] exp_ready);
        check_eq("wait_ready_c0", 32'(req_if.req_ready), 32'd0);
        for (int c = 1; c < LOCK_WAIT; c++) begin
            cyc();
            settle();
            check_eq("wait_ready", 32'(req_if.req_ready), 32'd0);
        end
        cyc();
        settle();
        check_eq("first_ready", 32'(req_if.req_ready), 32'(exp_ready));
    endtask

    // Called in the IDLE cycle where the handshake is expected; ends in the STOP cycle.
    task automatic frame_check(input int id, input logic [WIDTH-1:0] word);
        logic [WIDTH+1:0] bits;
        bits = {1'b1, word, 1'b0};
        check_eq("idle_line", 32'(data_out), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_ready", 32'(req_if.req_ready), 32'd1 << id);
        for (int c = 0; c < WIDTH + 2; c++) begin
            cyc();
            settle();
            check_eq("frame_line", 32'(data_out), 32'(bits[c]));
            check_eq("frame_busy", 32'(busy), 32'd1);
            check_eq("frame_ready", 32'(req_if.req_ready), 32'd0);
            check_eq("frame_grant", 32'(grant_id), 32'(id));
        end
    endtask

    initial begin
        dw[0] = 5'b00011;
        dw[1] = 5'b10101;
        dw[2] = 5'b01100;
        dw[3] = 5'b11110;

        // Reset values
        rst              = 1'b1;
        pll_lock         = 1'b0;
        req_if.req_valid = '0;
        req_if.req_data  = '0;
        cyc();
        cyc();
        settle();
        check_quiet("reset");
        check_eq("reset_grant", 32'(grant_id), 32'd0);

        // Lock qualification: ready first in cycle 16, frame 0,0,1,1,0,1,1
        cyc();
        rst              = 1'b0;
        pll_lock         = 1'b1;
        req_if.req_valid = 4'b0001;
        req_if.req_data  = {5'b0, 5'b0, 5'b0, 5'b10110};
        settle();
        lock_wait(4'b0001);
        frame_check(0, 5'b10110);

        // Round-robin from reset: 0,1,2,3,0 with one idle cycle between frames
        cyc();
        rst = 1'b1;
        cyc();
        rst              = 1'b0;
        req_if.req_valid = 4'b1111;
        req_if.req_data  = {dw[3], dw[2], dw[1], dw[0]};
        settle();
        lock_wait(4'b0001);
        frame_check(0, dw[0]);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            settle();
            frame_check(k % 4, dw[k % 4]);
        end

        // Skip idle requesters: last grant 1, valid 1001 -> 3 then 0
        cyc();
        settle();
        frame_check(1, dw[1]);
        cyc();
        req_if.req_valid = 4'b1001;
        settle();
        frame_check(3, dw[3]);
        cyc();
        settle();
        frame_check(0, dw[0]);

        // Abort during the third data bit, then relock resumes after last grant
        cyc();
        req_if.req_valid = 4'b0110;
        settle();
        check_eq("abort_hs_ready", 32'(req_if.req_ready), 32'b0010);
        cyc();
        cyc();
        cyc();
        cyc();
        pll_lock = 1'b0;
        settle();
        check_eq("abort_bit2", 32'(data_out), 32'(dw[1][2]));
        cyc();
        pll_lock = 1'b1;
        settle();
        check_quiet("abort");
        check_eq("abort_grant", 32'(grant_id), 32'd1);
        lock_wait(4'b0100);
        frame_check(2, dw[2]);

        // Lock loss in the IDLE handshake cycle consumes nothing
        cyc();
        pll_lock = 1'b0;
        settle();
        check_eq("lossidle_ready", 32'(req_if.req_ready), 32'd0);
        cyc();
        pll_lock = 1'b1;
        settle();
        lock_wait(4'b0010);
        frame_check(1, dw[1]);

        // Reset mid-frame: outputs return to reset values, priority restarts at 0
        cyc();
        req_if.req_valid = 4'b1111;
        settle();
        check_eq("rstmid_hs_ready", 32'(req_if.req_ready), 32'b0100);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        check_quiet("rstmid");
        check_eq("rstmid_grant", 32'(grant_id), 32'd0);
        lock_wait(4'b0001);
        frame_check(0, dw[0]);

        // Lock glitch: high 10 cycles, low 1, then ready 16 cycles after re-rise
        cyc();
        rst = 1'b1;
        cyc();
        rst              = 1'b0;
        req_if.req_valid = 4'b0001;
        settle();
        for (int c = 1; c < 10; c++) begin
            cyc();
            settle();
            check_eq("glitch_pre_ready", 32'(req_if.req_ready), 32'd0);
        end
        cyc();
        pll_lock = 1'b0;
        settle();
        check_eq("glitch_low_ready", 32'(req_if.req_ready), 32'd0);
        cyc();
        pll_lock = 1'b1;
        settle();
        lock_wait(4'b0001);
        frame_check(0, dw[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
